// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC defaults, interpolator state type and bit-growth helper
package cic_pkg;

  localparam int CIC_N_STAGES         = 3;
  localparam int CIC_INTERP_RATE      = 4;
  localparam int CIC_COMB_DELAY       = 1;
  localparam int CIC_IN_WIDTH         = 24;
  localparam int CIC_INTEGRATOR_WIDTH = 32;

  typedef enum logic {IDLE, EMIT} cic_interp_state_t;

  // Interpolators lose one factor of R because only one beat in R carries a sample.
  function automatic int cic_bit_growth(input int n, input int r, input int m, input bit decimate);
    int growth;
    growth = n * $clog2(r * m);
    return decimate ? growth : growth - $clog2(r);
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// rtl/cic_interpolator_if.sv - low-rate input and high-rate output valid/ready streams
interface cic_interpolator_if
  import cic_pkg::*;
#(
  parameter int WIDTH = CIC_IN_WIDTH
) ();

  logic signed [WIDTH-1:0] data_in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] data_out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid
  );

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid
  );

endinterface

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one CIC comb stage y = x - x[n-DELAY], advancing only on en
module cic_comb_stage #(
  parameter int WIDTH = 32,
  parameter int DELAY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);

  logic signed [WIDTH-1:0] dly [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) dly[i] <= '0;
    end else if (en) begin
      dly[0] <= x;
      for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  assign y = x - dly[DELAY-1];

endmodule

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - N-stage CIC interpolator, low-rate combs, high-rate integrators
// Optional CIC_INTERP_SAT_EN: saturating output rescale plus sticky o_sat_flag.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int N_STAGES         = CIC_N_STAGES,
  parameter int INTERP_RATE      = CIC_INTERP_RATE,
  parameter int COMB_DELAY       = CIC_COMB_DELAY,
  parameter int IN_WIDTH         = CIC_IN_WIDTH,
  parameter int BIT_GROWTH       = cic_bit_growth(N_STAGES, INTERP_RATE, COMB_DELAY, 1'b0),
  parameter int INTEGRATOR_WIDTH = CIC_INTEGRATOR_WIDTH
) (
  input  logic i_clk,
  input  logic rst,
  cic_interpolator_if.slave bus
`ifdef CIC_INTERP_SAT_EN
  ,
  output logic o_sat_flag
`endif
);

  localparam int W       = INTEGRATOR_WIDTH;
  localparam int PHASE_W = $clog2(INTERP_RATE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(INTERP_RATE - 1);

  cic_interp_state_t   state_q, state_d;
  logic [PHASE_W-1:0]  phase;
  logic signed [W-1:0] hold;
  logic signed [W-1:0] comb_x [N_STAGES+1];
  logic signed [W-1:0] stuff;
  logic signed [W-1:0] integ_out;
  logic signed [IN_WIDTH-1:0] scaled;
  logic step, accept, emit_step, last_phase, ready_c;

  assign step       = !bus.out_valid || bus.out_ready;
  assign last_phase = (phase == LAST_PHASE);
  assign emit_step  = (state_q == EMIT) && step;
  assign accept     = bus.in_valid && bus.in_ready;
  assign bus.in_ready = ready_c && !rst;

  // The last beat of a burst can pick up the next sample in the same cycle, so
  // in_ready follows out_ready combinationally there.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) state_d = EMIT;
      end
      EMIT: begin
        if (last_phase && step) begin
          ready_c = 1'b1;
          if (!bus.in_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign comb_x[0] = W'(bus.data_in);

  for (genvar s = 0; s < N_STAGES; s++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (W),
      .DELAY (COMB_DELAY)
    ) u_comb (
      .clk (i_clk),
      .rst (rst),
      .en  (accept),
      .x   (comb_x[s]),
      .y   (comb_x[s+1])
    );
  end

  // Zero-stuffing: only the first beat of each burst injects the held comb output.
  assign stuff = (phase == '0) ? hold : '0;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_integ
    logic signed [W-1:0] acc;
    logic signed [W-1:0] feed;
    if (g == 0) begin : g_first
      assign feed = stuff;
    end else begin : g_next
      assign feed = g_integ[g-1].acc;
    end
    always_ff @(posedge i_clk) begin
      if (rst)            acc <= '0;
      else if (emit_step) acc <= acc + feed;
    end
  end

  assign integ_out = g_integ[N_STAGES-1].acc;

`ifdef CIC_INTERP_SAT_EN
  localparam logic signed [W-1:0] SAT_MAX = {{(W-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

  logic signed [W-1:0] shifted;
  logic                clip;

  assign shifted = integ_out >>> BIT_GROWTH;

  always_comb begin
    clip   = 1'b0;
    scaled = shifted[IN_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      clip   = 1'b1;
      scaled = SAT_MAX[IN_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      clip   = 1'b1;
      scaled = SAT_MIN[IN_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst)                    o_sat_flag <= 1'b0;
    else if (emit_step && clip) o_sat_flag <= 1'b1;
  end
`else
  assign scaled = IN_WIDTH'(integ_out >>> BIT_GROWTH);
`endif

  always_ff @(posedge i_clk) begin
    if (rst) begin
      phase         <= '0;
      hold          <= '0;
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (accept) hold <= comb_x[N_STAGES];
      if (emit_step) begin
        bus.data_out  <= scaled;
        bus.out_valid <= 1'b1;
        phase         <= last_phase ? '0 : phase + PHASE_W'(1);
      end else if (state_q == IDLE && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - randomized bench against a convolution model of the CIC interpolator
module tb_cic_interpolator;

  localparam int N  = 3;
  localparam int R  = 4;
  localparam int M  = 1;
  localparam int IW = 24;
  localparam int BG = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cic_interpolator_if #(.WIDTH(IW)) bus ();

`ifdef CIC_INTERP_SAT_EN
  logic sat_flag;
`endif

  cic_interpolator #(
    .N_STAGES         (N),
    .INTERP_RATE      (R),
    .COMB_DELAY       (M),
    .IN_WIDTH         (IW),
    .BIT_GROWTH       (BG),
    .INTEGRATOR_WIDTH (32)
  ) dut (
    .i_clk (clk),
    .rst   (rst),
    .bus   (bus)
`ifdef CIC_INTERP_SAT_EN
    ,
    .o_sat_flag (sat_flag)
`endif
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint xin  [$];
  longint seen [$];
  longint h    [$];
  int     imp_tab [14];
  int     beat_idx, cyc, first_acc, first_vld;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Impulse response of the whole filter: boxcar of length R*M convolved N times.
  function automatic void build_h();
    longint t [$];
    h.delete();
    h.push_back(1);
    for (int s = 0; s < N; s++) begin
      t.delete();
      for (int i = 0; i < int'(h.size()) + R*M - 1; i++) t.push_back(0);
      for (int i = 0; i < int'(h.size()); i++)
        for (int j = 0; j < R*M; j++) t[i+j] += h[i];
      h = t;
    end
  endfunction

  function automatic longint model_beat(input int k);
    longint acc;
    int     p;
    logic signed [IW-1:0] t;
    acc = 0;
    for (int j = 0; j < int'(h.size()); j++) begin
      p = k - N - j;
      if (p >= 0 && (p % R) == 0 && (p / R) < int'(xin.size())) acc += h[j] * xin[p / R];
    end
    acc = acc >>> BG;
`ifdef CIC_INTERP_SAT_EN
    if (acc > (64'sd1 <<< (IW-1)) - 1) acc = (64'sd1 <<< (IW-1)) - 1;
    else if (acc < -(64'sd1 <<< (IW-1))) acc = -(64'sd1 <<< (IW-1));
    return acc;
`else
    t = acc[IW-1:0];
    return longint'(t);
`endif
  endfunction

  function automatic logic signed [IW-1:0] gen(input int kind, input longint val, input int idx);
    logic signed [IW-1:0] r;
    case (kind)
      0:       r = IW'($urandom);
      1:       r = IW'(val);
      default: r = (idx == 0) ? IW'(val) : '0;
    endcase
    return r;
  endfunction

  task automatic tick(input logic vld, input logic signed [IW-1:0] d, input logic rdy, output logic acc_o);
    @(negedge clk);
    bus.in_valid  = vld;
    bus.data_in   = d;
    bus.out_ready = rdy;
    #1;
    cyc++;
    if (bus.out_valid && first_vld < 0) first_vld = cyc;
    if (bus.out_valid && bus.out_ready) begin
      check_eq($sformatf("beat%0d", beat_idx), longint'(bus.data_out), model_beat(beat_idx));
      seen.push_back(longint'(bus.data_out));
      beat_idx++;
    end
    acc_o = vld && bus.in_ready;
    if (acc_o) begin
      xin.push_back(longint'(d));
      if (first_acc < 0) first_acc = cyc;
    end
  endtask

  task automatic run_stream(input int n, input int kind, input longint val, input int rdy_pct, input int gap_pct);
    int   got, guard;
    logic v, a, r;
    logic signed [IW-1:0] d;
    got = 0; guard = 0; v = 1'b0;
    d = gen(kind, val, 0);
    while (got < n && guard < 20*n + 100) begin
      if (!v) v = (int'($urandom_range(99)) >= gap_pct);
      r = (int'($urandom_range(99)) < rdy_pct);
      tick(v, d, r, a);
      guard++;
      if (a) begin
        got++;
        v = 1'b0;
        d = gen(kind, val, got);
      end
    end
    check_eq("stream_done", got, n);
  endtask

  task automatic reset_model();
    xin.delete();
    seen.delete();
    beat_idx  = 0;
    cyc       = 0;
    first_acc = -1;
    first_vld = -1;
  endtask

  task automatic check_impulse(input string tag);
    run_stream(14, 2, 16, 100, 0);
    check_eq({tag, "_len"}, longint'(seen.size() >= 14), 1);
    check_eq({tag, "_latency"}, first_vld - first_acc, 2);
    for (int k = 0; k < 14 && k < int'(seen.size()); k++)
      check_eq($sformatf("%s_tab%0d", tag, k), seen[k], imp_tab[k]);
  endtask

  initial begin
    logic a;
    int   cnt, g;
    longint snap_d, snap_v;

    imp_tab = '{0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};
    build_h();
    reset_model();
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_in_ready", longint'(bus.in_ready), 0);
    check_eq("reset_out_valid", longint'(bus.out_valid), 0);
    check_eq("reset_data_out", longint'(bus.data_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", longint'(bus.in_ready), 1);

    check_impulse("imp");

    run_stream(40, 1, 1000, 100, 0);
    check_eq("dc_settled", seen[$], 1000);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 24'sd1000, 1'b1, a);
      cnt += int'(a);
    end
    check_eq("dc_duty", cnt, 10);

    run_stream(200, 1, 8388607, 100, 0);
    check_eq("fs_settled", seen[$], 8388607);

    run_stream(6, 0, 0, 100, 0);
    tick(1'b0, '0, 1'b0, a);
    snap_d = longint'(bus.data_out);
    snap_v = longint'(bus.out_valid);
    check_eq("bp_valid", snap_v, 1);
    check_eq("bp_in_ready0", longint'(bus.in_ready), 0);
    for (int i = 1; i < 5; i++) begin
      tick(1'b0, '0, 1'b0, a);
      check_eq($sformatf("bp_data%0d", i), longint'(bus.data_out), snap_d);
      check_eq($sformatf("bp_vld%0d", i), longint'(bus.out_valid), snap_v);
      check_eq($sformatf("bp_in_ready%0d", i), longint'(bus.in_ready), 0);
    end
    run_stream(20, 0, 0, 100, 0);
    run_stream(100, 0, 0, 60, 30);

    a = 1'b0;
    g = 0;
    while (!a && g < 40) begin
      tick(1'b1, 24'sd1000, 1'b1, a);
      g++;
    end
    check_eq("rst_burst_acc", longint'(a), 1);
    tick(1'b0, '0, 1'b1, a);
    tick(1'b0, '0, 1'b1, a);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check_eq("rst_in_ready", longint'(bus.in_ready), 0);
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", longint'(bus.out_valid), 0);
    check_eq("rst_data_out", longint'(bus.data_out), 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    reset_model();
    check_impulse("imp2");

`ifdef CIC_INTERP_SAT_EN
    check_eq("sat_flag", longint'(sat_flag), 0);
`endif

    repeat (4) tick(1'b0, '0, 1'b1, a);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
